// File: rtl/vend_change_dispenser.sv
`default_nettype none
// ============================================================================
//  Module   : vend_change_dispenser
//  Purpose  : Pays a latched vending credit back as coins. Dollars are paid
//             first, then quarters. Each coin uses a request/ack handshake
//             with its hopper. The total returned is reported in cents.
//  Option   : VEND_CHANGE_ACK_TIMEOUT_EN - abort the payout and raise a
//             sticky fault when a hopper does not ack within ACK_TIMEOUT.
//  Revision : 1.0 - initial release
// ============================================================================
module vend_change_dispenser #(
  parameter int DOLLAR_UNITS = 4,
  parameter int GAP_CYCLES   = 2,
  parameter int ACK_TIMEOUT  = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        refund,
  input  logic [7:0]  balance,
  input  logic        dollar_empty,
  input  logic        quarter_empty,
  input  logic        coin_ack,
  output logic        credit_clr,
  output logic        dispense_dollar,
  output logic        dispense_quarter,
  output logic        busy,
  output logic        starved,
  output logic        done,
  output logic [11:0] returned_cents,
  output logic        fault
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_SELECT   = 3'd1;
  localparam logic [2:0] S_WAIT_ACK = 3'd2;
  localparam logic [2:0] S_GAP      = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;

  // One counter serves both the inter-coin gap and the ack watchdog.
  localparam int CNT_MAX = (GAP_CYCLES > ACK_TIMEOUT) ? GAP_CYCLES : ACK_TIMEOUT;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [6:0]       DOLLAR_REM   = 7'(DOLLAR_UNITS);
  localparam logic [11:0]      DOLLAR_CENTS = 12'(DOLLAR_UNITS * 25);
  localparam logic [11:0]      QUARTER_CENTS = 12'd25;

  logic [2:0]       r_state;
  logic [2:0]       w_state_nxt;
  logic             r_refund_prev;
  logic [6:0]       r_remaining;
  logic [11:0]      r_cents;
  logic             r_sel_dollar;
  logic             r_clr_pulse;
  logic [CNT_W-1:0] r_cnt;

  logic w_start;
  logic w_bal_pos;
  logic w_dollar_ok;
  logic w_coin_ok;
  logic w_gap_done;
  logic w_ack_expired;

  assign w_start     = refund & ~r_refund_prev;
  // Credit is signed: positive means bit 7 clear and a non-zero magnitude.
  assign w_bal_pos   = ~balance[7] & (balance[6:0] != 7'd0);
  assign w_dollar_ok = (r_remaining >= DOLLAR_REM) & ~dollar_empty;
  assign w_coin_ok   = w_dollar_ok | ~quarter_empty;
  assign w_gap_done  = (r_cnt == GAP_LAST);

`ifdef VEND_CHANGE_ACK_TIMEOUT_EN
  localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);
  logic r_fault;

  assign w_ack_expired = (r_cnt == ACK_LAST);
  assign fault         = r_fault;

  // Sticky watchdog flag, cleared only by reset or a new payout start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fault <= 1'b0;
    end else if (r_state == S_IDLE && w_start) begin
      r_fault <= 1'b0;
    end else if (r_state == S_WAIT_ACK && !coin_ack && w_ack_expired) begin
      r_fault <= 1'b1;
    end
  end
`else
  assign w_ack_expired = 1'b0;
  assign fault         = 1'b0;
`endif

  assign credit_clr     = r_clr_pulse;
  assign returned_cents = r_cents;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; coin choice is re-made on every SELECT visit.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_nxt = w_bal_pos ? S_SELECT : S_DONE;
        end
      end
      S_SELECT: begin
        if (r_remaining == 7'd0) begin
          w_state_nxt = S_DONE;
        end else if (w_coin_ok) begin
          w_state_nxt = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        if (coin_ack) begin
          w_state_nxt = (GAP_CYCLES == 0) ? S_SELECT : S_GAP;
        end else if (w_ack_expired) begin
          w_state_nxt = S_DONE;
        end
      end
      S_GAP: begin
        if (w_gap_done) begin
          w_state_nxt = S_SELECT;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Moore outputs from state; starved also looks at live hopper status.
  always_comb begin
    busy             = 1'b0;
    dispense_dollar  = 1'b0;
    dispense_quarter = 1'b0;
    starved          = 1'b0;
    done             = 1'b0;
    case (r_state)
      S_SELECT: begin
        busy    = 1'b1;
        starved = (r_remaining != 7'd0) & ~w_coin_ok;
      end
      S_WAIT_ACK: begin
        busy             = 1'b1;
        dispense_dollar  = r_sel_dollar;
        dispense_quarter = ~r_sel_dollar;
      end
      S_GAP:   busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Payout datapath: edge detect, latched balance, cents total, timers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_refund_prev <= 1'b0;
      r_remaining   <= 7'd0;
      r_cents       <= 12'd0;
      r_sel_dollar  <= 1'b0;
      r_clr_pulse   <= 1'b0;
      r_cnt         <= '0;
    end else begin
      r_refund_prev <= refund;
      r_clr_pulse   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_cents <= 12'd0;
            if (w_bal_pos) begin
              r_remaining <= balance[6:0];
              r_clr_pulse <= 1'b1;
            end
          end
        end
        S_SELECT: begin
          r_sel_dollar <= w_dollar_ok;
          r_cnt        <= '0;
        end
        S_WAIT_ACK: begin
          if (coin_ack) begin
            r_cnt <= '0;
            if (r_sel_dollar) begin
              r_remaining <= r_remaining - DOLLAR_REM;
              r_cents     <= r_cents + DOLLAR_CENTS;
            end else begin
              r_remaining <= r_remaining - 7'd1;
              r_cents     <= r_cents + QUARTER_CENTS;
            end
          end else begin
`ifdef VEND_CHANGE_ACK_TIMEOUT_EN
            r_cnt <= r_cnt + CNT_W'(1);
`endif
          end
        end
        S_GAP: r_cnt <= r_cnt + CNT_W'(1);
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vend_change_dispenser.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vend_change_dispenser
//  Purpose  : Scoreboard bench for vend_change_dispenser. Stimulus pushes the
//             expected payout, a monitor pops and compares on each done.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vend_change_dispenser;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        refund = 1'b0;
  logic [7:0]  balance = 8'd0;
  logic        dollar_empty;
  logic        quarter_empty = 1'b0;
  logic        coin_ack = 1'b0;
  logic        credit_clr, dispense_dollar, dispense_quarter, busy, starved, done, fault;
  logic [11:0] returned_cents;

  vend_change_dispenser dut (
    .clk(clk), .rst_n(rst_n), .refund(refund), .balance(balance),
    .dollar_empty(dollar_empty), .quarter_empty(quarter_empty), .coin_ack(coin_ack),
    .credit_clr(credit_clr), .dispense_dollar(dispense_dollar),
    .dispense_quarter(dispense_quarter), .busy(busy), .starved(starved),
    .done(done), .returned_cents(returned_cents), .fault(fault)
  );

  always #5 clk = ~clk;

  // Finite dollar hopper: stimulus sets the stock, the hopper counts coins out.
  int dollar_stock  = 0;
  int dollars_given = 0;
  assign dollar_empty = (dollars_given >= dollar_stock);

  int ack_delay = 2;
  bit hopper_on = 1'b1;

  typedef struct {
    int cents;
    int nd;
    int nq;
    int nclr;
    bit flt;
  } exp_t;
  exp_t sb[$];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Reference: positive credit is paid as many dollars as the stock and the
  // amount allow, the rest in quarters; non-positive credit pays nothing.
  function automatic exp_t model(input logic [7:0] bal, input int stock);
    exp_t e;
    int   rem;
    int   d;
    e = '{default: 0};
    if ($signed(bal) <= 0) return e;
    rem = int'(bal[6:0]);
    d   = rem / 4;
    if (d > stock) d = stock;
    e.nd    = d;
    e.nq    = rem - 4 * d;
    e.cents = 100 * d + 25 * e.nq;
    e.nclr  = 1;
    return e;
  endfunction

  // Hopper: acks each request ack_delay cycles after it appears.
  initial begin : hopper
    int wcnt;
    bit pend;
    wcnt = 0;
    pend = 1'b0;
    forever begin
      @(posedge clk); #1;
      coin_ack = 1'b0;
      if (!rst_n) begin
        pend = 1'b0;
      end else if (hopper_on && (dispense_dollar || dispense_quarter)) begin
        if (!pend) begin
          pend = 1'b1;
          wcnt = ack_delay;
        end
        if (wcnt == 0) begin
          coin_ack = 1'b1;
          pend     = 1'b0;
          if (dispense_dollar) dollars_given++;
        end else begin
          wcnt--;
        end
      end
    end
  end

  // Monitor: tallies requests and clears, then scores each done pulse.
  initial begin : monitor
    int   nd, nq, nclr;
    bit   prev_d, prev_q, seen_q;
    exp_t e;
    nd = 0; nq = 0; nclr = 0; prev_d = 0; prev_q = 0; seen_q = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        nd = 0; nq = 0; nclr = 0; prev_d = 0; prev_q = 0; seen_q = 0;
      end else begin
        if (dispense_dollar && dispense_quarter) check("both_requests", 1, 0);
        if (starved) check("starved_with_quarter", int'(quarter_empty), 1);
        if (dispense_dollar && !prev_d) begin
          nd++;
          if (seen_q) check("dollar_after_quarter", 1, 0);
        end
        if (dispense_quarter && !prev_q) begin
          nq++;
          seen_q = 1'b1;
        end
        if (credit_clr) nclr++;
        if (done) begin
          if (sb.size() == 0) begin
            check("unexpected_done", 1, 0);
          end else begin
            e = sb.pop_front();
            check("returned_cents", int'(returned_cents), e.cents);
            check("dollar_count", nd, e.nd);
            check("quarter_count", nq, e.nq);
            check("credit_clr_count", nclr, e.nclr);
            check("fault_at_done", int'(fault), int'(e.flt));
            check("busy_at_done", int'(busy), 0);
          end
          nd = 0; nq = 0; nclr = 0; seen_q = 0;
        end
        prev_d = dispense_dollar;
        prev_q = dispense_quarter;
      end
    end
  end

  task automatic arm(input logic [7:0] bal, input int stock);
    @(posedge clk); #1;
    refund       = 1'b0;
    balance      = bal;
    dollar_stock = dollars_given + stock;
    @(posedge clk); #1;
  endtask

  task automatic payout(input logic [7:0] bal, input int stock, input bit jitter,
                        input bit repress, input bit lat);
    bit got;
    got = 1'b0;
    arm(bal, stock);
    sb.push_back(model(bal, stock));
    refund = 1'b1;
    for (int cyc = 0; cyc < 5000 && !got; cyc++) begin
      @(posedge clk); #1;
      if (lat && cyc == 0) begin
        check("latency_credit_clr", int'(credit_clr), 1);
        check("latency_busy", int'(busy), 1);
      end
      if (lat && cyc == 1) begin
        check("latency_first_dollar", int'(dispense_dollar), 1);
        check("credit_clr_one_cycle", int'(credit_clr), 0);
      end
      if (done) begin
        got    = 1'b1;
        refund = 1'b0;
      end else begin
        if (cyc == 3) refund = 1'b0;
        if (repress && busy && cyc > 3) refund = 1'($urandom_range(0, 1));
        if (jitter) begin
          if ($urandom_range(0, 7) == 0) quarter_empty = 1'b1;
          else if ($urandom_range(0, 1) == 0) quarter_empty = 1'b0;
        end
      end
    end
    quarter_empty = 1'b0;
    refund        = 1'b0;
    check("done_seen", int'(got), 1);
  endtask

  task automatic wait_done(input string name);
    bit got;
    got = 1'b0;
    for (int cyc = 0; cyc < 5000 && !got; cyc++) begin
      @(posedge clk); #1;
      if (done) got = 1'b1;
    end
    check(name, int'(got), 1);
  endtask

  task automatic wait_request(input bit dollar, input string name);
    bit got;
    got = 1'b0;
    for (int cyc = 0; cyc < 500 && !got; cyc++) begin
      @(posedge clk); #1;
      if (dollar ? dispense_dollar : dispense_quarter) got = 1'b1;
    end
    check(name, int'(got), 1);
  endtask

  initial begin : stimulus
    logic [7:0] bal;
    int         r;
    int         n;
    exp_t       e;

    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", int'({credit_clr, dispense_dollar, dispense_quarter, busy,
                                 starved, done, fault, returned_cents}), 0);
    rst_n = 1'b1;

    // Case 1: 1 dollar + 3 quarters, with request latency and a re-press.
    ack_delay = 2;
    payout(8'd7, 10, 1'b0, 1'b0, 1'b1);
    payout(8'd7, 10, 1'b0, 1'b1, 1'b0);
    // Case 2 and 3: quarter-only payouts, dollar hopper running out.
    payout(8'd3, 10, 1'b0, 1'b0, 1'b0);
    payout(8'd5, 0, 1'b0, 1'b0, 1'b0);
    payout(8'd9, 1, 1'b0, 1'b0, 1'b0);
    // Case 4: zero and negative credit pay nothing.
    payout(8'd0, 10, 1'b0, 1'b0, 1'b0);
    payout(8'hFE, 10, 1'b0, 1'b0, 1'b0);

    // Case 5: quarter hopper empties after the first quarter.
    arm(8'd2, 0);
    sb.push_back(model(8'd2, 0));
    refund = 1'b1;
    wait_request(1'b0, "first_quarter_seen");
    refund        = 1'b0;
    quarter_empty = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("starved_held", int'(starved), 1);
    check("busy_while_starved", int'(busy), 1);
    quarter_empty = 1'b0;
    #1;
    check("starved_released", int'(starved), 0);
    wait_done("done_after_starve");

    // Case 6: asynchronous reset in the middle of a dollar request.
    ack_delay = 6;
    arm(8'd7, 10);
    refund = 1'b1;
    wait_request(1'b1, "dollar_before_reset");
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", int'({credit_clr, dispense_dollar, dispense_quarter, busy,
                                       starved, done, fault, returned_cents}), 0);
    refund = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n     = 1'b1;
    ack_delay = 1;
    payout(8'd3, 10, 1'b0, 1'b0, 1'b0);

`ifdef VEND_CHANGE_ACK_TIMEOUT_EN
    // Hopper never acks: request drops after the watchdog, coin not counted.
    hopper_on = 1'b0;
    arm(8'd3, 0);
    e      = '{default: 0};
    e.nq   = 1;
    e.nclr = 1;
    e.flt  = 1'b1;
    sb.push_back(e);
    refund = 1'b1;
    wait_request(1'b0, "timeout_request_seen");
    refund = 1'b0;
    n = 1;
    for (int cyc = 0; cyc < 200 && dispense_quarter; cyc++) begin
      @(posedge clk); #1;
      if (dispense_quarter) n++;
    end
    check("timeout_request_cycles", n, 64);
    wait_done("timeout_done");
    hopper_on = 1'b1;
    payout(8'd1, 0, 1'b0, 1'b0, 1'b0);
`endif

    // Randomized payouts.
    for (int i = 0; i < 24; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 2)       bal = 8'($urandom_range(128, 255));
      else if (r == 2) bal = 8'($urandom_range(41, 127));
      else             bal = 8'($urandom_range(0, 40));
      ack_delay = int'($urandom_range(0, 3));
      payout(bal, int'($urandom_range(0, 8)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'b0);
    end

    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vend_change_dispenser.md
Name: vend_change_dispenser

Overview:
- Return-side counterpart of the vending machine's coin acceptor.
- On a refund request, it clears the machine's credit, then pays the latched balance back as physical coins. Dollars are paid first, then quarters.
- Each coin is driven to the coin hopper with a request/acknowledge handshake. The total returned is reported in cents.
- Sits between the vending machine credit register and the two coin hoppers.

Parameters:
- DOLLAR_UNITS, 4: quarter units per dollar coin.
- GAP_CYCLES, 2: idle cycles between successive coin requests; 0 is legal.
- ACK_TIMEOUT, 64: cycles to wait for coin_ack before fault (used only with the optional feature).

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- refund  input  1  refund button; its rising edge starts a payout.
- balance  input  8  signed credit in quarter units, in the same format as the machine's internal credit.
- dollar_empty  input  1  dollar hopper empty.
- quarter_empty  input  1  quarter hopper empty.
- coin_ack  input  1  hopper has released the requested coin.
- credit_clr  output  1  one-cycle pulse telling the machine to zero its credit.
- dispense_dollar  output  1  dollar coin request; held until acknowledged.
- dispense_quarter  output  1  quarter coin request; held until acknowledged.
- busy  output  1  high from payout start until DONE.
- starved  output  1  payout stalled because no usable coin is available.
- done  output  1  one-cycle pulse at payout completion.
- returned_cents  output  12  cents paid in the last payout.
- fault  output  1  sticky ack-timeout flag.

Behaviour:
- Reset: all outputs are 0, refund_prev=0, state IDLE. Reset is asynchronous, so any in-flight request drops immediately and no credit is restored.
- Edge detection: refund_prev is registered each cycle. A start is refund_prev==0 && refund==1.
- Refund edges are ignored while busy.

State machine (IDLE, SELECT, WAIT_ACK, GAP, DONE):
- IDLE, on start with balance <= 0 (signed compare): go to DONE. returned_cents=0; credit_clr is not pulsed.
- IDLE, on start with balance > 0:
  - latch remaining=balance[6:0]
  - set returned_cents=0 and clear fault
  - pulse credit_clr for 1 cycle, set busy=1
  - go to SELECT.
- SELECT, evaluated in priority order:
  - remaining==0: go to DONE.
  - remaining >= DOLLAR_UNITS && !dollar_empty: dispense_dollar=1, go to WAIT_ACK.
  - !quarter_empty: dispense_quarter=1, go to WAIT_ACK.
  - otherwise: stay in SELECT with starved=1. starved deasserts on the cycle a coin becomes selectable.
- Coin choice is re-evaluated on every SELECT visit, so a dollar hopper emptying mid-payout falls back to quarters.
- WAIT_ACK:
  - Hold the request line until coin_ack==1 is sampled.
  - On that edge: drop the request, remaining -= 4 or 1, returned_cents += 100 or 25.
  - Then go to GAP (or SELECT if GAP_CYCLES==0).
  - Exactly one of dispense_dollar / dispense_quarter is ever high.
- coin_ack outside WAIT_ACK is ignored.
- GAP: count GAP_CYCLES, then go to SELECT.
- DONE: done=1 for one cycle, busy=0, go to IDLE.
- returned_cents holds its value until the next start.

Widths:
- remaining is 7-bit unsigned; it cannot underflow, because a dollar is only chosen when remaining >= 4.
- returned_cents maximum is 127*25=3175, which fits in 12 bits with no saturation.

Latency: start edge, then credit_clr/busy on the next cycle, then the first request one cycle later.

Optional Feature:
- Macro: VEND_CHANGE_ACK_TIMEOUT_EN.
- Defined:
  - WAIT_ACK counts cycles.
  - If ACK_TIMEOUT cycles elapse without coin_ack: drop the request, set fault=1 (sticky), go to DONE. The unacknowledged coin is not added to returned_cents.
  - fault clears on reset or the next start.
- Undefined: WAIT_ACK waits indefinitely, fault is tied to 0, and ACK_TIMEOUT is unused.

Test Plan:
1. balance=7, hoppers full, ack 2 cycles after each request, GAP_CYCLES=2 -> one credit_clr pulse; requests are 1 dollar then 3 quarters; returned_cents=175; one done pulse.
2. balance=3 -> 3 quarter requests, no dollar request; returned_cents=75.
3. balance=5, dollar_empty=1 -> 5 quarters, returned_cents=125. Repeat with dollar_empty rising after the first dollar for balance=9 -> 1 dollar + 5 quarters, returned_cents=225.
4. balance=0, then balance=-2 (0xFE) -> no requests, no credit_clr, done pulse, returned_cents=0. A refund re-pressed while busy during case 1 -> no effect.
5. balance=2, quarter_empty=1 after the first quarter -> starved=1 and busy=1 hold; release quarter_empty -> second quarter paid, returned_cents=50.
6. rst_n low during WAIT_ACK of case 1 -> all outputs 0 immediately, state IDLE. With VEND_CHANGE_ACK_TIMEOUT_EN and ACK_TIMEOUT=64, no ack -> request drops after 64 cycles, fault=1, done pulse, returned_cents excludes the unacknowledged coin.
